// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit bus CPU: control word, opcodes and micro-step numbers.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package cpu_pkg;

    // One strobe per bus client; first field is the MSB of the packed word.
    typedef struct packed {
        logic hlt;
        logic mar_in;
        logic ram_in;
        logic ram_out;
        logic ir_in;
        logic ir_out;
        logic a_in;
        logic a_out;
        logic b_in;
        logic alu_out;
        logic alu_sub;
        logic flags_in;
        logic out_in;
        logic pc_inc;
        logic pc_out;
        logic pc_jump;
    } ctrl_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;

endpackage

// File: rtl/microcode_rom.sv
// Microcode table: (opcode, step, carry, zero) -> control word.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the step advances.
module microcode_rom
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 3
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [STEP_W-1:0]   step,
    input  logic                carry,
    input  logic                zero,
    output ctrl_t               ctrl
);

    logic is_t0;
    logic is_t1;
    logic is_t2;
    logic is_t3;
    logic is_t4;

    assign is_t0 = (step == STEP_W'(T0));
    assign is_t1 = (step == STEP_W'(T1));
    assign is_t2 = (step == STEP_W'(T2));
    assign is_t3 = (step == STEP_W'(T3));
    assign is_t4 = (step == STEP_W'(T4));

    // Fetch is shared by every opcode; execute words follow the opcode table.
    // Steps past T4 and undefined opcodes produce an empty word.
    always_comb begin
        ctrl = '0;
        if (is_t0) begin
            ctrl.pc_out = 1'b1;
            ctrl.mar_in = 1'b1;
        end else if (is_t1) begin
            ctrl.ram_out = 1'b1;
            ctrl.ir_in   = 1'b1;
            ctrl.pc_inc  = 1'b1;
        end else begin
            case (opcode)
                OPCODE_W'(OP_LDA): begin
                    if (is_t2) begin
                        ctrl.ir_out = 1'b1;
                        ctrl.mar_in = 1'b1;
                    end
                    if (is_t3) begin
                        ctrl.ram_out = 1'b1;
                        ctrl.a_in    = 1'b1;
                    end
                end
                OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
                    if (is_t2) begin
                        ctrl.ir_out = 1'b1;
                        ctrl.mar_in = 1'b1;
                    end
                    if (is_t3) begin
                        ctrl.ram_out = 1'b1;
                        ctrl.b_in    = 1'b1;
                    end
                    if (is_t4) begin
                        ctrl.alu_out  = 1'b1;
                        ctrl.a_in     = 1'b1;
                        ctrl.flags_in = 1'b1;
                        ctrl.alu_sub  = (opcode == OPCODE_W'(OP_SUB));
                    end
                end
                OPCODE_W'(OP_STA): begin
                    if (is_t2) begin
                        ctrl.ir_out = 1'b1;
                        ctrl.mar_in = 1'b1;
                    end
                    if (is_t3) begin
                        ctrl.a_out  = 1'b1;
                        ctrl.ram_in = 1'b1;
                    end
                end
                OPCODE_W'(OP_LDI): begin
                    if (is_t2) begin
                        ctrl.ir_out = 1'b1;
                        ctrl.a_in   = 1'b1;
                    end
                end
                OPCODE_W'(OP_JMP): begin
                    if (is_t2) begin
                        ctrl.ir_out  = 1'b1;
                        ctrl.pc_jump = 1'b1;
                    end
                end
                OPCODE_W'(OP_JC): begin
                    if (is_t2 && carry) begin
                        ctrl.ir_out  = 1'b1;
                        ctrl.pc_jump = 1'b1;
                    end
                end
                OPCODE_W'(OP_JZ): begin
                    if (is_t2 && zero) begin
                        ctrl.ir_out  = 1'b1;
                        ctrl.pc_jump = 1'b1;
                    end
                end
                OPCODE_W'(OP_OUT): begin
                    if (is_t2) begin
                        ctrl.a_out  = 1'b1;
                        ctrl.out_in = 1'b1;
                    end
                end
                OPCODE_W'(OP_HLT): begin
                    if (is_t2) begin
                        ctrl.hlt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/microcode_sequencer.sv
// CPU control unit: steps each instruction through fetch/execute, with halt and illegal-op latches.
// Latency: ctrl is combinational from the registered step; step/halted/illegal move on enabled clk edges.
// Backpressure: step_en low freezes all state; once halted, step_en is ignored until reset.
module microcode_sequencer
    import cpu_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int DATA_W    = 8,
    parameter int STEPS     = 5,
    parameter int EARLY_END = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     step_en,
    input  logic [DATA_W-1:0]        instr,
    input  logic                     carry,
    input  logic                     zero,
    output ctrl_t                    ctrl,
    output logic [$clog2(STEPS)-1:0] step,
    output logic                     halted,
    output logic                     illegal
);

    localparam int STEP_W = $clog2(STEPS);

    logic [OPCODE_W-1:0] opcode;
    logic [STEP_W-1:0]   step_ahead;
    logic [STEP_W-1:0]   step_next;
    ctrl_t               word_now;
    ctrl_t               word_ahead;
    logic                at_t2;
    logic                is_last;
    logic                early_done;
    logic                op_hlt;
    logic                op_illegal;
    logic                unused_operand;

    // The operand field is consumed by the datapath over the bus, never here.
    assign opcode         = instr[DATA_W-1 -: OPCODE_W];
    assign unused_operand = ^instr[DATA_W-OPCODE_W-1:0];

    assign step_ahead = step + STEP_W'(1);
    assign at_t2      = (step == STEP_W'(T2));
    assign is_last    = (step == STEP_W'(STEPS - 1));
    assign op_hlt     = (opcode == OPCODE_W'(OP_HLT));

    microcode_rom #(
        .OPCODE_W (OPCODE_W),
        .STEP_W   (STEP_W)
    ) u_rom_now (
        .opcode (opcode),
        .step   (step),
        .carry  (carry),
        .zero   (zero),
        .ctrl   (word_now)
    );

    // Lookahead copy: an empty word at step+1 means the instruction is finished.
    // A wrapped step_ahead only happens on the last step, where we wrap anyway.
    microcode_rom #(
        .OPCODE_W (OPCODE_W),
        .STEP_W   (STEP_W)
    ) u_rom_ahead (
        .opcode (opcode),
        .step   (step_ahead),
        .carry  (carry),
        .zero   (zero),
        .ctrl   (word_ahead)
    );

    // Opcodes without a microcode entry execute as NOP but get flagged.
    always_comb begin
        case (opcode)
            OPCODE_W'(OP_NOP), OPCODE_W'(OP_LDA), OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB),
            OPCODE_W'(OP_STA), OPCODE_W'(OP_LDI), OPCODE_W'(OP_JMP), OPCODE_W'(OP_JC),
            OPCODE_W'(OP_JZ),  OPCODE_W'(OP_OUT), OPCODE_W'(OP_HLT): op_illegal = 1'b0;
            default:                                                 op_illegal = 1'b1;
        endcase
    end

    // Next step: wrap after the last step, or return early once the remaining words are empty.
    always_comb begin
        early_done = (EARLY_END != 0) && (step >= STEP_W'(T2)) && (word_ahead == '0);
        if (is_last || early_done) begin
            step_next = '0;
        end else begin
            step_next = step_ahead;
        end
    end

    // Step counter and sticky latches; HLT parks the sequencer on T2 until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step    <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else if (step_en && !halted) begin
            if (at_t2 && op_hlt) begin
                halted <= 1'b1;
            end else begin
                step <= step_next;
            end
            if (at_t2 && op_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

    // While halted only the hlt strobe is driven, whatever the instruction register holds.
    always_comb begin
        ctrl = word_now;
        if (halted) begin
            ctrl     = '0;
            ctrl.hlt = 1'b1;
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
`timescale 1ns/1ps
module tb_microcode_sequencer;
    import cpu_pkg::*;

    localparam logic [15:0] M_HLT      = 16'h8000;
    localparam logic [15:0] M_MAR_IN   = 16'h4000;
    localparam logic [15:0] M_RAM_IN   = 16'h2000;
    localparam logic [15:0] M_RAM_OUT  = 16'h1000;
    localparam logic [15:0] M_IR_IN    = 16'h0800;
    localparam logic [15:0] M_IR_OUT   = 16'h0400;
    localparam logic [15:0] M_A_IN     = 16'h0200;
    localparam logic [15:0] M_A_OUT    = 16'h0100;
    localparam logic [15:0] M_B_IN     = 16'h0080;
    localparam logic [15:0] M_ALU_OUT  = 16'h0040;
    localparam logic [15:0] M_ALU_SUB  = 16'h0020;
    localparam logic [15:0] M_FLAGS_IN = 16'h0010;
    localparam logic [15:0] M_OUT_IN   = 16'h0008;
    localparam logic [15:0] M_PC_INC   = 16'h0004;
    localparam logic [15:0] M_PC_OUT   = 16'h0002;
    localparam logic [15:0] M_PC_JUMP  = 16'h0001;
    localparam logic [15:0] W_T0 = M_PC_OUT | M_MAR_IN;
    localparam logic [15:0] W_T1 = M_RAM_OUT | M_IR_IN | M_PC_INC;

    typedef struct packed {
        logic [3:0] st;
        logic       h;
        logic       il;
    } mst_t;

    logic       clk;
    logic       rst_n, rst_n8;
    logic       step_en, step_en8;
    logic [7:0] instr, instr8;
    logic       carry, zero;
    ctrl_t      ctrl, ctrl8;
    logic [2:0] step, step8;
    logic       halted, halted8, illegal, illegal8;

    int   errors = 0;
    int   checks = 0;
    mst_t m, m8;

    microcode_sequencer #(.OPCODE_W(4), .DATA_W(8), .STEPS(5), .EARLY_END(1)) dut (
        .clk(clk), .rst_n(rst_n), .step_en(step_en), .instr(instr), .carry(carry), .zero(zero),
        .ctrl(ctrl), .step(step), .halted(halted), .illegal(illegal)
    );

    microcode_sequencer #(.OPCODE_W(4), .DATA_W(8), .STEPS(8), .EARLY_END(0)) dut8 (
        .clk(clk), .rst_n(rst_n8), .step_en(step_en8), .instr(instr8), .carry(carry), .zero(zero),
        .ctrl(ctrl8), .step(step8), .halted(halted8), .illegal(illegal8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the instruction table as written, execute words listed for T2..T4.
    function automatic logic [15:0] mword(input logic [3:0] op, input int t, input logic c, input logic z);
        logic [15:0] ex [3];
        ex = '{16'h0, 16'h0, 16'h0};
        case (op)
            4'h1: ex = '{M_IR_OUT | M_MAR_IN, M_RAM_OUT | M_A_IN, 16'h0};
            4'h2: ex = '{M_IR_OUT | M_MAR_IN, M_RAM_OUT | M_B_IN, M_ALU_OUT | M_A_IN | M_FLAGS_IN};
            4'h3: ex = '{M_IR_OUT | M_MAR_IN, M_RAM_OUT | M_B_IN, M_ALU_OUT | M_A_IN | M_FLAGS_IN | M_ALU_SUB};
            4'h4: ex = '{M_IR_OUT | M_MAR_IN, M_A_OUT | M_RAM_IN, 16'h0};
            4'h5: ex = '{M_IR_OUT | M_A_IN, 16'h0, 16'h0};
            4'h6: ex = '{M_IR_OUT | M_PC_JUMP, 16'h0, 16'h0};
            4'h7: if (c) ex = '{M_IR_OUT | M_PC_JUMP, 16'h0, 16'h0};
            4'h8: if (z) ex = '{M_IR_OUT | M_PC_JUMP, 16'h0, 16'h0};
            4'hE: ex = '{M_A_OUT | M_OUT_IN, 16'h0, 16'h0};
            4'hF: ex = '{M_HLT, 16'h0, 16'h0};
            default: ;
        endcase
        if (t == 0) return W_T0;
        if (t == 1) return W_T1;
        if (t >= 2 && t <= 4) return ex[t-2];
        return 16'h0;
    endfunction

    // Instruction length in steps: trimmed after the last non-empty word when ending early.
    function automatic int steps_for(input logic [3:0] op, input logic c, input logic z,
                                     input int early, input int steps);
        int n;
        if (early == 0) return steps;
        n = 3;
        for (int t = 3; t <= 4; t++) if (mword(op, t, c, z) != 16'h0) n = t + 1;
        return n;
    endfunction

    function automatic mst_t m_next(input mst_t s, input logic [3:0] op, input logic c, input logic z,
                                    input int early, input int steps);
        mst_t n;
        n = s;
        if (s.h) return n;
        if (s.st == 4'd2 && op == 4'hF) begin
            n.h = 1'b1;
            return n;
        end
        if (s.st == 4'd2 && op >= 4'h9 && op <= 4'hD) n.il = 1'b1;
        if (int'(s.st) + 1 >= steps_for(op, c, z, early, steps)) n.st = 4'd0;
        else n.st = s.st + 4'd1;
        return n;
    endfunction

    // One clock edge; both reference models follow their own enables.
    task automatic tick();
        mst_t n1, n2;
        n1 = m_next(m, instr[7:4], carry, zero, 1, 5);
        n2 = m_next(m8, instr8[7:4], carry, zero, 0, 8);
        @(posedge clk);
        if (step_en) m = n1;
        if (step_en8) m8 = n2;
        #1;
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        rst_n8 = 1'b0;
        m = '0;
        m8 = '0;
        #2;
        rst_n = 1'b1;
        rst_n8 = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0]  exp_step [3];
        logic [15:0] exp_word [3];
        exp_step = '{3'd1, 3'd2, 3'd0};
        exp_word = '{W_T1, 16'h0, W_T0};
        instr = 8'h00; instr8 = 8'h00; step_en = 1'b0; step_en8 = 1'b0; carry = 1'b0; zero = 1'b0;
        rst_n = 1'b0; rst_n8 = 1'b0; m = '0; m8 = '0;
        #2;
        checks++; if (step !== 3'd0) begin errors++; $display("FAIL reset_step got=%0d exp=0", step); end
        checks++; if ({halted, illegal} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {halted, illegal}); end
        checks++; if (ctrl !== W_T0) begin errors++; $display("FAIL reset_ctrl got=%h exp=%h", ctrl, W_T0); end
        checks++; if (ctrl8 !== W_T0) begin errors++; $display("FAIL reset_ctrl8 got=%h exp=%h", ctrl8, W_T0); end
        rst_n = 1'b1; rst_n8 = 1'b1;
        step_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (step !== exp_step[i]) begin errors++; $display("FAIL nop_step[%0d] got=%0d exp=%0d", i, step, exp_step[i]); end
            checks++; if (ctrl !== exp_word[i]) begin errors++; $display("FAIL nop_ctrl[%0d] got=%h exp=%h", i, ctrl, exp_word[i]); end
        end
    endtask

    task automatic test_add();
        logic [15:0] w [5];
        w = '{W_T0, W_T1, M_IR_OUT | M_MAR_IN, M_RAM_OUT | M_B_IN, M_ALU_OUT | M_A_IN | M_FLAGS_IN};
        hard_reset();
        instr = 8'h2E; step_en = 1'b1; carry = 1'b1; zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (step !== 3'(i)) begin errors++; $display("FAIL add_step[%0d] got=%0d exp=%0d", i, step, i); end
            checks++; if (ctrl !== w[i]) begin errors++; $display("FAIL add_ctrl[%0d] got=%h exp=%h", i, ctrl, w[i]); end
            tick();
        end
        checks++; if (step !== 3'd0) begin errors++; $display("FAIL add_wrap got=%0d exp=0", step); end
    endtask

    task automatic test_cond_jump();
        logic [7:0]  ci [4];
        logic        cc [4];
        logic        cz [4];
        logic [15:0] ct2 [4];
        ci  = '{8'h7A, 8'h7A, 8'h85, 8'h85};
        cc  = '{1'b0, 1'b1, 1'b1, 1'b0};
        cz  = '{1'b1, 1'b0, 1'b0, 1'b1};
        ct2 = '{16'h0, M_IR_OUT | M_PC_JUMP, 16'h0, M_IR_OUT | M_PC_JUMP};
        hard_reset();
        step_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr = ci[k]; carry = cc[k]; zero = cz[k];
            tick();
            tick();
            checks++; if (step !== 3'd2) begin errors++; $display("FAIL jump_t2_step[%0d] got=%0d exp=2", k, step); end
            checks++; if (ctrl !== ct2[k]) begin errors++; $display("FAIL jump_t2_ctrl[%0d] got=%h exp=%h", k, ctrl, ct2[k]); end
            tick();
            checks++; if (step !== 3'd0) begin errors++; $display("FAIL jump_end[%0d] got=%0d exp=0", k, step); end
        end
    endtask

    task automatic test_halt();
        hard_reset();
        instr = 8'hF0; step_en = 1'b1; carry = 1'b0; zero = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set got=%b exp=1", halted); end
        checks++; if (ctrl !== M_HLT) begin errors++; $display("FAIL halt_ctrl got=%h exp=%h", ctrl, M_HLT); end
        instr = 8'h20;
        for (int i = 0; i < 10; i++) begin
            step_en = 1'($urandom);
            tick();
        end
        step_en = 1'b1;
        checks++; if (step !== 3'd2) begin errors++; $display("FAIL halt_frozen got=%0d exp=2", step); end
        checks++; if ({halted, ctrl} !== {1'b1, M_HLT}) begin errors++; $display("FAIL halt_hold got=%b/%h exp=1/%h", halted, ctrl, M_HLT); end
        rst_n = 1'b0; m = '0;
        #1;
        checks++; if ({halted, step} !== 4'b0000) begin errors++; $display("FAIL halt_clear got=%b/%0d exp=0/0", halted, step); end
        rst_n = 1'b1;
    endtask

    task automatic test_illegal();
        hard_reset();
        instr = 8'hB0; step_en = 1'b1;
        tick();
        tick();
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_early got=%b exp=0", illegal); end
        tick();
        checks++; if ({illegal, step} !== 4'b1000) begin errors++; $display("FAIL illegal_set got=%b/%0d exp=1/0", illegal, step); end
        tick();
        checks++; if (ctrl !== W_T1) begin errors++; $display("FAIL illegal_refetch got=%h exp=%h", ctrl, W_T1); end
        step_en = 1'b0; instr8 = 8'hB0; step_en8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (step8 !== 3'(i)) begin errors++; $display("FAIL full_step[%0d] got=%0d exp=%0d", i, step8, i); end
            checks++; if (ctrl8 !== (i == 0 ? W_T0 : (i == 1 ? W_T1 : 16'h0))) begin
                errors++; $display("FAIL full_ctrl[%0d] got=%h", i, ctrl8);
            end
            tick();
        end
        checks++; if ({illegal8, step8} !== 4'b1000) begin errors++; $display("FAIL full_wrap got=%b/%0d exp=1/0", illegal8, step8); end
        step_en8 = 1'b0;
    endtask

    task automatic test_async_reset_hold();
        hard_reset();
        instr = 8'h1C; step_en = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (ctrl !== (M_RAM_OUT | M_A_IN)) begin errors++; $display("FAIL lda_t3 got=%h exp=%h", ctrl, M_RAM_OUT | M_A_IN); end
        #2;
        rst_n = 1'b0; m = '0;
        #1;
        checks++; if ({step, ctrl} !== {3'd0, W_T0}) begin errors++; $display("FAIL async_rst got=%0d/%h exp=0/%h", step, ctrl, W_T0); end
        rst_n = 1'b1;
        tick();
        checks++; if (ctrl !== W_T1) begin errors++; $display("FAIL post_rst got=%h exp=%h", ctrl, W_T1); end
        step_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({step, ctrl} !== {3'd1, W_T1}) begin errors++; $display("FAIL hold[%0d] got=%0d/%h exp=1/%h", i, step, ctrl, W_T1); end
        end
    endtask

    task automatic test_random();
        logic [15:0] exp;
        hard_reset();
        for (int i = 0; i < 400; i++) begin
            if ((m.h && $urandom_range(0, 3) == 0) || $urandom_range(0, 60) == 0) hard_reset();
            if (m.st == 4'd0 && !m.h) instr = 8'($urandom);
            carry = 1'($urandom);
            zero = 1'($urandom);
            step_en = ($urandom_range(0, 3) != 0);
            #1;
            exp = m.h ? M_HLT : mword(instr[7:4], int'(m.st), carry, zero);
            checks++; if (ctrl !== exp) begin errors++; $display("FAIL rand_ctrl[%0d] instr=%h got=%h exp=%h", i, instr, ctrl, exp); end
            tick();
            checks++; if ({illegal, halted, step} !== {m.il, m.h, m.st[2:0]}) begin
                errors++; $display("FAIL rand_state[%0d] got=%b exp=%b", i, {illegal, halted, step}, {m.il, m.h, m.st[2:0]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_cond_jump();
        test_halt();
        test_illegal();
        test_async_reset_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
